// File: rtl/array_2d_stream_flattener.sv
// Captures a ROWSxCOLS element array in one handshake and replays it as LANES-wide beats,
// in row- or column-major order, with a keep mask on the final partial beat and an end marker.
module array_2d_stream_flattener #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_WIDTH-1:0]         in_data [ROWS-1:0][COLS-1:0],
  input  logic                         in_col_major,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*BIT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]             out_keep,
  output logic                         out_last,
  output logic                         busy
);

  localparam int N_ELEM  = ROWS * COLS;
  localparam int N_BEATS = (N_ELEM + LANES - 1) / LANES;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int BEAT_W  = LANES * BIT_WIDTH;
  localparam int N_PAD   = N_BEATS * LANES;
  localparam int PAD_W   = (N_PAD - N_ELEM) * BIT_WIDTH;
  localparam int TAIL    = N_ELEM - (N_BEATS - 1) * LANES;
  localparam logic [LANES-1:0] LAST_KEEP = {LANES{1'b1}} >> (LANES - TAIL);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [N_ELEM*BIT_WIDTH-1:0]  data_q, data_d;
  logic [N_ELEM*BIT_WIDTH-1:0]  cap_data;
  logic [N_PAD*BIT_WIDTH-1:0]   padded;
  logic                         at_last;

  // The array is reordered at capture so that stored element k is already the k-th
  // element of the output stream; the beat mux then only needs the beat counter.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_cap
    localparam int ROW_R = gi / COLS;
    localparam int COL_R = gi % COLS;
    localparam int ROW_C = gi % ROWS;
    localparam int COL_C = gi / ROWS;
    assign cap_data[gi*BIT_WIDTH +: BIT_WIDTH] =
      in_col_major ? in_data[ROW_C][COL_C] : in_data[ROW_R][COL_R];
  end

  // Lanes past the last real element read constant zero.
  if (PAD_W > 0) begin : g_pad
    assign padded = {{PAD_W{1'b0}}, data_q};
  end else begin : g_nopad
    assign padded = data_q;
  end

  assign at_last = (cnt_q == CNT_W'(N_BEATS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          state_d = S_STREAM;
          cnt_d   = '0;
          data_d  = cap_data;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = padded[32'(cnt_q) * BEAT_W +: BEAT_W];
        out_keep  = at_last ? LAST_KEEP : {LANES{1'b1}};
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_array_2d_stream_flattener.sv
// Bench for array_2d_stream_flattener: a 2x3 byte instance with 4 lanes and a default-sized
// instance, checked by per-scenario tasks plus a scoreboard fed at input acceptance.
module tb_array_2d_stream_flattener;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Small instance: 8-bit elements, 2 rows, 3 columns, 4 lanes -> 2 beats
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [7:0]  a_in_data [1:0][2:0];
  logic        a_in_col = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_keep;
  logic        a_out_last;
  logic        a_busy;

  // Default instance: 4-bit elements, 8x8, 4 lanes -> 16 beats
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [3:0]  b_in_data [7:0][7:0];
  logic        b_in_col = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic        b_out_last;
  logic        b_busy;

  beat_t a_q[$];
  beat_t b_q[$];
  int    acc_cnt_a = 0;
  int    acc_cyc_a = -1;
  int    last_cyc_a = -1;

  array_2d_stream_flattener #(.BIT_WIDTH(8), .ROWS(2), .COLS(3), .LANES(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_col_major(a_in_col), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_keep(a_out_keep),
    .out_last(a_out_last), .busy(a_busy)
  );

  array_2d_stream_flattener dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_col_major(b_in_col), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_keep(b_out_keep),
    .out_last(b_out_last), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  // Scoreboard producers: on every accepted array, push its expected beats.
  always @(negedge clk) begin : mon_in_a
    beat_t e;
    int k, r, c;
    #1;
    if (!rst && a_in_valid && a_in_ready) begin
      acc_cnt_a++;
      acc_cyc_a = cyc + 1;
      for (int b = 0; b < 2; b++) begin
        e.d = '0; e.k = '0; e.l = (b == 1);
        for (int l = 0; l < 4; l++) begin
          k = b * 4 + l;
          if (k < 6) begin
            if (a_in_col) begin r = k % 2; c = k / 2; end
            else          begin r = k / 3; c = k % 3; end
            e.d[l*8 +: 8] = a_in_data[r][c];
            e.k[l] = 1'b1;
          end
        end
        a_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon_in_b
    beat_t e;
    int k, r, c;
    #1;
    if (!rst && b_in_valid && b_in_ready) begin
      for (int b = 0; b < 16; b++) begin
        e.d = '0; e.k = 4'hF; e.l = (b == 15);
        for (int l = 0; l < 4; l++) begin
          k = b * 4 + l;
          if (b_in_col) begin r = k % 8; c = k / 8; end
          else          begin r = k / 8; c = k % 8; end
          e.d[l*4 +: 4] = b_in_data[r][c];
        end
        b_q.push_back(e);
      end
    end
  end

  // Scoreboard consumers: compare every beat that the next edge will hand over.
  always @(negedge clk) begin : mon_out_a
    beat_t e;
    #1;
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_beat: got data=%h last=%b, required no beat", a_out_data, a_out_last);
      end else begin
        e = a_q.pop_front();
        n_checks++;
        if (a_out_data !== e.d) begin
          n_fail++; $display("FAIL a_sb_data: got %h required %h", a_out_data, e.d);
        end
        n_checks++;
        if (a_out_keep !== e.k) begin
          n_fail++; $display("FAIL a_sb_keep: got %h required %h", a_out_keep, e.k);
        end
        n_checks++;
        if (a_out_last !== e.l) begin
          n_fail++; $display("FAIL a_sb_last: got %b required %b", a_out_last, e.l);
        end
      end
      if (a_out_last) last_cyc_a = cyc + 1;
    end
  end

  always @(negedge clk) begin : mon_out_b
    beat_t e;
    #1;
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_beat: got data=%h last=%b, required no beat", b_out_data, b_out_last);
      end else begin
        e = b_q.pop_front();
        n_checks++;
        if (b_out_data !== e.d[15:0]) begin
          n_fail++; $display("FAIL b_sb_data: got %h required %h", b_out_data, e.d[15:0]);
        end
        n_checks++;
        if (b_out_keep !== e.k) begin
          n_fail++; $display("FAIL b_sb_keep: got %h required %h", b_out_keep, e.k);
        end
        n_checks++;
        if (b_out_last !== e.l) begin
          n_fail++; $display("FAIL b_sb_last: got %b required %b", b_out_last, e.l);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_a(input int base);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        a_in_data[r][c] = 8'(base + 16 * r + c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fill_a(0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b_in_data[r][c] = 4'((r + c) & 15);
    repeat (3) step();
    #1;
    n_checks++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_a_ctrl: got valid/last/busy/in_ready=%b required 0000",
                         {a_out_valid, a_out_last, a_busy, a_in_ready});
    end
    n_checks++;
    if ({a_out_keep, a_out_data} !== 36'h0) begin
      n_fail++; $display("FAIL reset_a_data: got keep=%h data=%h required 0", a_out_keep, a_out_data);
    end
    n_checks++;
    if ({b_out_valid, b_in_ready, b_busy, b_out_keep, b_out_data} !== 23'h0) begin
      n_fail++; $display("FAIL reset_b: got valid=%b in_ready=%b busy=%b keep=%h data=%h required 0",
                         b_out_valid, b_in_ready, b_busy, b_out_keep, b_out_data);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 11", {a_in_ready, b_in_ready});
    end
  endtask

  task automatic test_row_major();
    step();
    fill_a(0); a_in_col = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_busy, a_in_ready} !== 3'b110) begin
      n_fail++; $display("FAIL t1_latency: got valid/busy/in_ready=%b required 110", {a_out_valid, a_busy, a_in_ready});
    end
    n_checks++;
    if ({a_out_data, a_out_keep, a_out_last} !== {32'h10020100, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL t1_beat0: got data=%h keep=%h last=%b required 10020100 f 0", a_out_data, a_out_keep, a_out_last);
    end
    step();
    n_checks++;
    if ({a_out_data, a_out_keep, a_out_last} !== {32'h00001211, 4'h3, 1'b1}) begin
      n_fail++; $display("FAIL t1_beat1: got data=%h keep=%h last=%b required 00001211 3 1", a_out_data, a_out_keep, a_out_last);
    end
    step();
    n_checks++;
    if ({a_out_valid, a_in_ready, a_busy} !== 3'b010) begin
      n_fail++; $display("FAIL t1_idle: got valid/in_ready/busy=%b required 010", {a_out_valid, a_in_ready, a_busy});
    end
  endtask

  task automatic test_col_major();
    step();
    fill_a(0); a_in_col = 1'b1; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_data, a_out_keep, a_out_last} !== {32'h11011000, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL t2_beat0: got data=%h keep=%h last=%b required 11011000 f 0", a_out_data, a_out_keep, a_out_last);
    end
    step();
    n_checks++;
    if ({a_out_data, a_out_keep, a_out_last} !== {32'h00001202, 4'h3, 1'b1}) begin
      n_fail++; $display("FAIL t2_beat1: got data=%h keep=%h last=%b required 00001202 3 1", a_out_data, a_out_keep, a_out_last);
    end
    step();
  endtask

  task automatic test_backpressure();
    step();
    fill_a(0); a_in_col = 1'b0; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, 32'h10020100, 1'b0}) begin
        n_fail++; $display("FAIL t3_stall cycle %0d: got valid=%b data=%h last=%b required 1 10020100 0",
                           i, a_out_valid, a_out_data, a_out_last);
      end
      a_in_col = ~a_in_col;
      a_in_data[1][2] = 8'(8'hE0 + i);
      step();
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < 20 && a_q.size() != 0; i++) step();
    n_checks++;
    if (a_q.size() !== 0) begin
      n_fail++; $display("FAIL t3_drain: got %0d beats outstanding required 0", a_q.size());
    end
  endtask

  task automatic test_defaults();
    int lasts;
    lasts = 0;
    step();
    b_in_col = 1'b0; b_out_ready = 1'b1; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (b_out_valid !== 1'b1) begin
        n_fail++; $display("FAIL t4_valid beat %0d: got %b required 1", i, b_out_valid);
      end
      if (i == 0) begin
        n_checks++;
        if (b_out_data !== 16'h3210) begin
          n_fail++; $display("FAIL t4_beat0: got %h required 3210", b_out_data);
        end
      end
      if (i < 15 && b_out_last) lasts++;
      if (i == 15) begin
        n_checks++;
        if ({b_out_data, b_out_last} !== {16'hEDCB, 1'b1}) begin
          n_fail++; $display("FAIL t4_beat15: got data=%h last=%b required edcb 1", b_out_data, b_out_last);
        end
      end
      step();
    end
    n_checks++;
    if (lasts !== 0) begin
      n_fail++; $display("FAIL t4_early_last: got %0d early last beats required 0", lasts);
    end
    n_checks++;
    if ({b_out_valid, b_in_ready, b_q.size() == 0} !== 3'b011) begin
      n_fail++; $display("FAIL t4_end: got valid=%b in_ready=%b outstanding=%0d required 0 1 0",
                         b_out_valid, b_in_ready, b_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int viol, first_last, second_acc;
    bit seen2;
    viol = 0; seen2 = 1'b0; first_last = -1; second_acc = -1;
    step();
    acc_cnt_a = 0;
    fill_a(8'h40); a_in_col = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 30 && !seen2; i++) begin
      step();
      if (a_busy && a_in_ready) viol++;
      if (acc_cnt_a == 1) begin
        fill_a(8'h80); a_in_col = 1'b1;
      end
      if (acc_cnt_a >= 2) begin
        seen2 = 1'b1; a_in_valid = 1'b0;
        first_last = last_cyc_a; second_acc = acc_cyc_a;
      end
    end
    for (int i = 0; i < 20 && a_q.size() != 0; i++) begin
      step();
      if (a_busy && a_in_ready) viol++;
    end
    n_checks++;
    if (seen2 !== 1'b1) begin
      n_fail++; $display("FAIL t5_second_accept: got none required accepted");
    end
    n_checks++;
    if (second_acc - first_last !== 1) begin
      n_fail++; $display("FAIL t5_gap: got %0d cycles between last handshake and accept required 1",
                         second_acc - first_last);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL t5_ready_in_stream: got %0d cycles with in_ready during stream required 0", viol);
    end
    n_checks++;
    if (a_q.size() !== 0) begin
      n_fail++; $display("FAIL t5_drain: got %0d beats outstanding required 0", a_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int saved_last;
    step();
    fill_a(0); a_in_col = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    saved_last = last_cyc_a;
    rst = 1'b1;
    a_q.delete();
    step();
    n_checks++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      n_fail++; $display("FAIL t6_abort: got valid=%b busy=%b required 0 0", a_out_valid, a_busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t6_ready_after_rst: got %b required 1", a_in_ready);
    end
    n_checks++;
    if (last_cyc_a !== saved_last) begin
      n_fail++; $display("FAIL t6_no_last: got last handshake at cycle %0d required none", last_cyc_a);
    end
    step();
    fill_a(0); a_in_col = 1'b1; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_data} !== {1'b1, 32'h11011000}) begin
      n_fail++; $display("FAIL t6_restart_beat0: got valid=%b data=%h required 1 11011000", a_out_valid, a_out_data);
    end
    for (int i = 0; i < 20 && a_q.size() != 0; i++) step();
    n_checks++;
    if (a_q.size() !== 0) begin
      n_fail++; $display("FAIL t6_drain: got %0d beats outstanding required 0", a_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_defaults();
    test_back_to_back();
    test_reset_abort();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
